rgb2yuv_ctrl: RTL and testbench

Sequencing controller for the JPEG colour-conversion stage. It accepts block-ordered RGB pixels from the pixel fetcher through a valid/ready handshake and issues them to the free-running 1-cycle-latency RGB-to-YUV converter only when downstream space is guaranteed. It captures converted pixels in a 3-entry output FIFO and presents them to the DCT with valid/ready plus block and frame markers. The converter has no stall input, so this block owns all flow control around it.

---
 rtl/rgb2yuv_ctrl.sv | 97 +++++++++
 tb/tb_rgb2yuv_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb2yuv_ctrl.sv
// rgb2yuv_ctrl: flow control around a stall-free 1-cycle RGB->YUV converter with a 3-entry output FIFO.
// Optional framing check on pixel_in_sof enabled by defining RGB2YUV_CTRL_SOF_CHK_EN.
module rgb2yuv_ctrl #(
    parameter int BLK_PER_FRM = 4800,
    parameter int BLK_CNT_W   = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pixel_in_data,
    input  logic        pixel_in_valid,
    input  logic        pixel_in_sof,
    output logic        pixel_in_ready,
    output logic [23:0] cvt_data_in,
    output logic        cvt_in_valid,
    input  logic [23:0] cvt_data_out,
    input  logic        cvt_out_valid,
    output logic [23:0] yuv_data,
    output logic        yuv_valid,
    input  logic        yuv_ready,
    output logic        yuv_sob,
    output logic        yuv_eob,
    output logic        yuv_eof,
    output logic        busy,
    output logic        err
);
    logic [5:0]           pix_cnt, pix_eff;
    logic [BLK_CNT_W-1:0] blk_cnt, blk_eff;
    logic [1:0]           occ, wr_ptr, rd_ptr;
    logic [26:0]          mem [3];
    logic [26:0]          head;
    logic [2:0]           tag, tag_q;
    logic                 inflight, accept, restart, err_set, err_q, wr, rd, last_blk;

    // occ + inflight counts every pixel that already owns a FIFO slot
    assign pixel_in_ready = ~rst & (({1'b0, occ} + {2'b0, inflight}) <= 3'd2);
    assign accept         = pixel_in_valid & pixel_in_ready;
    assign cvt_data_in    = pixel_in_data;
    assign cvt_in_valid   = accept;

`ifdef RGB2YUV_CTRL_SOF_CHK_EN
    assign restart = pixel_in_sof & ((pix_cnt != 6'd0) | (blk_cnt != '0));
    assign err_set = accept & (restart | ((pix_cnt == 6'd0) & (blk_cnt == '0) & ~pixel_in_sof));
`else
    logic unused_sof;
    assign unused_sof = pixel_in_sof;
    assign restart    = 1'b0;
    assign err_set    = 1'b0;
`endif

    assign pix_eff  = restart ? 6'd0 : pix_cnt;
    assign blk_eff  = restart ? '0 : blk_cnt;
    assign last_blk = blk_eff == BLK_CNT_W'(BLK_PER_FRM - 1);
    assign tag      = {(pix_eff == 6'd63) & last_blk, pix_eff == 6'd63, pix_eff == 6'd0};

    assign wr = inflight & cvt_out_valid;
    assign rd = yuv_valid & yuv_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt  <= '0;
            blk_cnt  <= '0;
            inflight <= 1'b0;
            tag_q    <= '0;
            occ      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            err_q    <= 1'b0;
        end else begin
            inflight <= accept;
            tag_q    <= tag;
            err_q    <= err_q | err_set;
            if (accept) begin
                pix_cnt <= pix_eff + 6'd1;
                blk_cnt <= (pix_eff == 6'd63) ? (last_blk ? '0 : blk_eff + BLK_CNT_W'(1)) : blk_eff;
            end
            if (wr)
                wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            if (rd)
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            occ <= occ + 2'(wr) - 2'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= {tag_q, cvt_data_out};
    end

    assign head      = mem[rd_ptr];
    assign yuv_valid = occ != 2'd0;
    assign yuv_data  = head[23:0];
    assign yuv_sob   = yuv_valid & head[24];
    assign yuv_eob   = yuv_valid & head[25];
    assign yuv_eof   = yuv_valid & head[26];
    assign busy      = (pix_cnt != 6'd0) | (blk_cnt != '0) | inflight | yuv_valid;
    assign err       = err_q;
endmodule

// File: tb/tb_rgb2yuv_ctrl.sv
// tb_rgb2yuv_ctrl: randomized bench for rgb2yuv_ctrl against a pixel-position/queue reference model.
module tb_rgb2yuv_ctrl;
    localparam int BPF = 3;
    localparam int FRM = 64 * BPF;

    logic        clk = 1'b0, rst = 1'b1;
    logic [23:0] pixel_in_data = '0, cvt_data_in, cvt_data_out, yuv_data;
    logic        pixel_in_valid = 1'b0, pixel_in_sof = 1'b0, pixel_in_ready;
    logic        cvt_in_valid, cvt_out_valid, yuv_valid, yuv_ready = 1'b0;
    logic        yuv_sob, yuv_eob, yuv_eof, busy, err;

    always #5 clk = ~clk;

    rgb2yuv_ctrl #(.BLK_PER_FRM(BPF), .BLK_CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .pixel_in_data(pixel_in_data), .pixel_in_valid(pixel_in_valid),
        .pixel_in_sof(pixel_in_sof), .pixel_in_ready(pixel_in_ready),
        .cvt_data_in(cvt_data_in), .cvt_in_valid(cvt_in_valid),
        .cvt_data_out(cvt_data_out), .cvt_out_valid(cvt_out_valid),
        .yuv_data(yuv_data), .yuv_valid(yuv_valid), .yuv_ready(yuv_ready),
        .yuv_sob(yuv_sob), .yuv_eob(yuv_eob), .yuv_eof(yuv_eof),
        .busy(busy), .err(err)
    );

    function automatic logic [23:0] conv(input logic [23:0] p);
        int r, g, b, y, u, v;
        r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
        y = (77 * r + 150 * g + 29 * b) >>> 8;
        u = ((128 * b - 43 * r - 85 * g) >>> 8) + 128;
        v = ((128 * r - 107 * g - 21 * b) >>> 8) + 128;
        return {y[7:0], u[7:0], v[7:0]};
    endfunction

    // Free-running converter; spur injects result strobes with no matching input.
    logic        cv_q = 1'b0, spur = 1'b0;
    logic [23:0] cd_q = '0;
    always_ff @(posedge clk) begin
        cv_q <= cvt_in_valid;
        cd_q <= conv(cvt_data_in);
    end
    assign cvt_out_valid = cv_q | spur;
    assign cvt_data_out  = cd_q;

    int          n_tests = 0, n_fail = 0, n_acc = 0, n_out = 0, pos = 0, cyc = 0;
    int          t_acc = -1, t_val = -1;
    bit          acc_prev = 0, exp_err = 0, pending = 0;
    logic [26:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_accept(input logic [23:0] d, input logic sof);
`ifdef RGB2YUV_CTRL_SOF_CHK_EN
        if (sof && pos != 0) begin
            exp_err = 1;
            pos = 0;
        end else if (pos == 0 && !sof)
            exp_err = 1;
`endif
        exp_q.push_back({pos == FRM - 1, pos % 64 == 63, pos % 64 == 0, conv(d)});
        pos = (pos + 1) % FRM;
    endfunction

    task automatic cycle();
        bit acc, vexp;
        int out;
        @(negedge clk);
        cyc++;
        if (rst) begin
            chk("rst_ready", 32'(pixel_in_ready), 0);
            chk("rst_valid", 32'(yuv_valid), 0);
            chk("rst_markers", 32'({yuv_sob, yuv_eob, yuv_eof}), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_cvt_v", 32'(cvt_in_valid), 0);
            exp_q.delete();
            pos = 0; exp_err = 0; acc_prev = 0; pending = 0;
        end else begin
            out  = exp_q.size();
            vexp = (out - int'(acc_prev)) > 0;
            chk("ready", 32'(pixel_in_ready), 32'(out <= 2));
            chk("yuv_valid", 32'(yuv_valid), 32'(vexp));
            chk("busy", 32'(busy), 32'(pos != 0 || out != 0));
            chk("err", 32'(err), 32'(exp_err));
            acc = pixel_in_valid & pixel_in_ready;
            chk("cvt_in_valid", 32'(cvt_in_valid), 32'(acc));
            if (acc) chk("cvt_data_in", 32'(cvt_data_in), 32'(pixel_in_data));
            if (yuv_valid) begin
                if (t_val < 0) t_val = cyc;
                if (out == 0) chk("head_unexpected", 32'(yuv_valid), 0);
                else begin
                    chk("head", 32'({yuv_eof, yuv_eob, yuv_sob, yuv_data}), 32'(exp_q[0]));
                    if (yuv_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (acc) begin
                if (t_acc < 0) t_acc = cyc;
                model_accept(pixel_in_data, pixel_in_sof);
                n_acc++;
            end
            acc_prev = acc;
            pending  = pixel_in_valid & ~acc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit rdy, input bit force_sof);
        if (!pending) begin
            pixel_in_valid = v;
            pixel_in_data  = 24'($urandom);
`ifdef RGB2YUV_CTRL_SOF_CHK_EN
            pixel_in_sof = force_sof | (pos == 0);
`else
            pixel_in_sof = force_sof | 1'($urandom_range(0, 1));
`endif
        end
        yuv_ready = rdy;
        spur      = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int n, input int rdy_pct);
        int a0 = n_acc;
        for (int i = 0; i < 20 * n + 50 && n_acc - a0 < n; i++) begin
            drive(1, $urandom_range(0, 99) < rdy_pct, 0);
            cycle();
        end
        chk("send_budget", 32'(n_acc - a0), 32'(n));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (exp_q.size() != 0 || pending); i++) begin
            drive(0, 1, 0);
            cycle();
        end
        chk("drain_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int a0, o0, c0;
        repeat (3) cycle();
        rst = 1'b0;

        // back-to-back block, latency and throughput
        t_acc = -1; t_val = -1; c0 = cyc;
        send(64, 100);
        chk("t1_tput_cycles", 32'(cyc - c0), 64);
        chk("t1_latency", 32'(t_val - t_acc), 2);
        drain();
        chk("t1_outputs", 32'(n_out), 64);

        // backpressure: only three pixels fit
        a0 = n_acc; o0 = n_out;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0);
            cycle();
        end
        chk("bp_accepted", 32'(n_acc - a0), 3);
        chk("bp_ready_low", 32'(pixel_in_ready), 0);
        send(7, 100);
        drain();
        chk("bp_outputs", 32'(n_out - o0), 10);

        // finish the frame: eof then idle
        send(FRM - pos, 100);
        drain();
        chk("frame_idle_busy", 32'(busy), 0);

        // random valid/ready
        o0 = n_out;
        for (int i = 0; i < 6000 && n_out - o0 < 1000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 0);
            cycle();
            if (n_acc - a0 >= 1000 + 10 + FRM - 74) pixel_in_valid = pending;
        end
        drain();
        chk("rnd_outputs_min", 32'(n_out - o0 >= 1000), 1);

        // reset mid-frame
        send(FRM - pos, 100);
        drain();
        send(37, 60);
        pixel_in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        o0 = n_out;
        send(64, 80);
        drain();
        chk("rst_outputs", 32'(n_out - o0), 64);

        // sof on pixel 20 of a fresh frame
        send(FRM - pos, 100);
        drain();
        a0 = n_acc;
        for (int i = 0; i < 1000 && n_acc - a0 < 90; i++) begin
            drive(1, $urandom_range(0, 3) != 0, n_acc - a0 == 20);
            cycle();
        end
        drain();
        chk("sof_err", 32'(err), 32'(exp_err));
`ifdef RGB2YUV_CTRL_SOF_CHK_EN
        chk("sof_err_set", 32'(exp_err), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
